fetch_pipe_regs: RTL
====================

Name: fetch_pipe_regs

Overview:
- Consumer end of the hazard-control interface. Applies IFstall/PCStall/IFFlush/EXNop/PCsrc to the actual PC register, IF/ID register and ID/EX control register.
- Sits between the hazard unit, instruction memory and the decode stage. Owns next-PC selection and bubble insertion.
- Keeps saturating stall/flush/bubble event counters for debug and performance.

Parameters:
PC_W, 32, width of PC and branch/jump targets
INST_W, 32, instruction width
CTRL_W, 10, width of the ID-stage control bundle registered into ID/EX
CNT_W, 16, width of each event counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
PCStall  in  1  hold PC this cycle
IFstall  in  1  hold IF/ID this cycle
IFFlush  in  1  squash IF/ID this cycle
EXNop  in  1  insert bubble into ID/EX
PCsrc  in  2  next-PC select: 01 PC+4, 00 branch target, 10 jump target, 11 illegal
branch_target  in  PC_W  branch destination from ID
jump_target  in  PC_W  jump destination from ID
inst_in  in  INST_W  instruction memory data for address pc
id_ctrl_in  in  CTRL_W  decoded control bundle of instruction in ID
cnt_clr  in  1  synchronous clear of event counters
pc  out  PC_W  current fetch address
ifid_inst  out  INST_W  IF/ID instruction
ifid_pc4  out  PC_W  IF/ID PC+4
ifid_valid  out  1  IF/ID holds a real instruction
idex_ctrl  out  CTRL_W  ID/EX control bundle
idex_valid  out  1  ID/EX holds a real instruction
stall_cnt  out  CNT_W  cycles with PCStall or IFstall
flush_cnt  out  CNT_W  flushes actually applied to IF/ID
bubble_cnt  out  CNT_W  cycles with EXNop
pcsrc_err  out  1  sticky: PCsrc==11 observed while PCStall==0

Behaviour:
- Reset (rst=1 at edge): all outputs, including pc and pcsrc_err, go to 0. rst has priority over every other input.
- pc4 = pc + 4, computed modulo 2^PC_W. 0xFFFFFFFC wraps to 0 with no flag.
- PC register, priority order:
  - PCStall=1: hold.
  - Else PCsrc 01: pc4.
  - Else PCsrc 00: branch_target.
  - Else PCsrc 10: jump_target.
  - Else PCsrc 11: pc4, and set pcsrc_err.
- Stall wins over redirect. A branch/jump coinciding with a load-use stall is simply re-presented next cycle, because the instruction is still held in ID.
- IF/ID register, priority order:
  - IFstall=1: hold all three fields.
  - Else IFFlush=1: ifid_inst=0 (nop), ifid_pc4=0, ifid_valid=0.
  - Else: ifid_inst=inst_in, ifid_pc4=pc4, ifid_valid=1.
- IFstall=1 with PCStall=0 is legal and unprotected: PC advances and the fetched word is dropped.
- ID/EX control register:
  - EXNop=1: idex_ctrl=0, idex_valid=0.
  - Else: idex_ctrl=id_ctrl_in, idex_valid=ifid_valid (old value).
- Latency: one cycle per register. Redirect visible on pc the cycle after PCsrc selects it. The first target instruction reaches ifid_inst one cycle later.
- Counters: each saturates at all-ones (no wrap). Priority is rst > cnt_clr > increment.
  - stall_cnt: +1 when PCStall|IFstall.
  - flush_cnt: +1 when IFFlush & ~IFstall.
  - bubble_cnt: +1 when EXNop.
- cnt_clr does not affect pipeline state. Reset mid-stall or mid-flush discards all state; the first fetch after reset is from address 0.

Test Plan:
- Reset then 4 cycles of PCsrc=01, no hazards, inst_in=0xA0+pc:
  - pc runs 0,4,8,12,16.
  - ifid_inst=0xA0, 0xA4, … one cycle behind.
  - ifid_valid=1 from the second edge; idex_valid follows one cycle later.
- Load-use: at pc=8, pulse PCStall=IFstall=EXNop=1 for one cycle:
  - pc stays 8; ifid_inst unchanged; idex_ctrl=0, idex_valid=0.
  - stall_cnt=1, bubble_cnt=1.
  - Normal flow resumes next cycle.
- Taken branch: PCsrc=00, branch_target=0x40, IFFlush=EXNop=1 for one cycle:
  - next pc=0x40; ifid_valid=0, ifid_inst=0; flush_cnt=1.
  - The following cycle ifid_inst=inst_in@0x40.
- Jump plus load-use in the same cycle (PCStall=IFstall=IFFlush=EXNop=1, PCsrc=10):
  - pc held, IF/ID held, flush_cnt unchanged.
  - Next cycle jump alone (IFFlush=1, PCsrc=10, jump_target=0x100) gives pc=0x100.
- Counter saturation with CNT_W=4: hold EXNop=1 for 20 cycles → bubble_cnt=15. Pulse cnt_clr → 0.
- PCsrc=11 at pc=0x20 → pc=0x24 and pcsrc_err=1 stays set; rst mid-sequence returns pc, pcsrc_err and counters to 0.

Source files
------------

// File: rtl/fetch_pipe_regs_if.sv
// Hazard-control / fetch bus seen by the PC, IF/ID and ID/EX registers.
// The slave side is the register block; the master side drives hazard
// controls, fetch data and decode control and observes the pipeline state.
interface fetch_pipe_regs_if #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int CTRL_W = 10,
    parameter int CNT_W  = 16
);
    logic              PCStall;
    logic              IFstall;
    logic              IFFlush;
    logic              EXNop;
    logic [1:0]        PCsrc;
    logic [PC_W-1:0]   branch_target;
    logic [PC_W-1:0]   jump_target;
    logic [INST_W-1:0] inst_in;
    logic [CTRL_W-1:0] id_ctrl_in;
    logic              cnt_clr;

    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] ifid_inst;
    logic [PC_W-1:0]   ifid_pc4;
    logic              ifid_valid;
    logic [CTRL_W-1:0] idex_ctrl;
    logic              idex_valid;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic [CNT_W-1:0]  bubble_cnt;
    logic              pcsrc_err;

    modport master (
        output PCStall, IFstall, IFFlush, EXNop, PCsrc,
               branch_target, jump_target, inst_in, id_ctrl_in, cnt_clr,
        input  pc, ifid_inst, ifid_pc4, ifid_valid, idex_ctrl, idex_valid,
               stall_cnt, flush_cnt, bubble_cnt, pcsrc_err
    );

    modport slave (
        input  PCStall, IFstall, IFFlush, EXNop, PCsrc,
               branch_target, jump_target, inst_in, id_ctrl_in, cnt_clr,
        output pc, ifid_inst, ifid_pc4, ifid_valid, idex_ctrl, idex_valid,
               stall_cnt, flush_cnt, bubble_cnt, pcsrc_err
    );
endinterface

// File: rtl/fetch_pipe_regs.sv
// Front-end pipeline registers: PC with next-PC selection, IF/ID with
// stall/flush, ID/EX control with bubble insertion, plus saturating
// stall/flush/bubble event counters and a sticky illegal-PCsrc flag.
module fetch_pipe_regs #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int CTRL_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic           clk,
    input  logic           rst,
    fetch_pipe_regs_if.slave bus
);

    localparam logic [1:0] SEL_BRANCH = 2'b00;
    localparam logic [1:0] SEL_PC4    = 2'b01;
    localparam logic [1:0] SEL_JUMP   = 2'b10;

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic en);
        if (en && (v != {CNT_W{1'b1}}))
            return v + CNT_W'(1);
        return v;
    endfunction

    logic [PC_W-1:0]   pc_p0;
    logic [PC_W-1:0]   pc4_p0;
    logic              pcsrc_err_r;

    logic [INST_W-1:0] ifid_inst_p1;
    logic [PC_W-1:0]   ifid_pc4_p1;
    logic              ifid_vld_p1;

    logic [CTRL_W-1:0] idex_ctrl_p2;
    logic              idex_vld_p2;

    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  flush_cnt_r;
    logic [CNT_W-1:0]  bubble_cnt_r;

    logic              stall_evt;
    logic              flush_evt;
    logic              bubble_evt;

    // Sequential fetch address; wraps silently at the top of the space.
    assign pc4_p0 = pc_p0 + PC_W'(4);

    // Event qualifiers: a flush only counts when IF/ID is not held.
    assign stall_evt  = bus.PCStall | bus.IFstall;
    assign flush_evt  = bus.IFFlush & ~bus.IFstall;
    assign bubble_evt = bus.EXNop;

    // ---- stage p0: PC register; stall beats any redirect ----
    // PC update with next-PC select and sticky illegal-select flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p0       <= '0;
            pcsrc_err_r <= 1'b0;
        end else if (!bus.PCStall) begin
            unique case (bus.PCsrc)
                SEL_PC4:    pc_p0 <= pc4_p0;
                SEL_BRANCH: pc_p0 <= bus.branch_target;
                SEL_JUMP:   pc_p0 <= bus.jump_target;
                default: begin
                    pc_p0       <= pc4_p0;
                    pcsrc_err_r <= 1'b1;
                end
            endcase
        end
    end

    // ---- stage p1: IF/ID register ----
    // IF/ID capture: hold on stall, squash to a nop on flush, else load.
    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_inst_p1 <= '0;
            ifid_pc4_p1  <= '0;
            ifid_vld_p1  <= 1'b0;
        end else if (bus.IFstall) begin
            ifid_inst_p1 <= ifid_inst_p1;
            ifid_pc4_p1  <= ifid_pc4_p1;
            ifid_vld_p1  <= ifid_vld_p1;
        end else if (bus.IFFlush) begin
            ifid_inst_p1 <= '0;
            ifid_pc4_p1  <= '0;
            ifid_vld_p1  <= 1'b0;
        end else begin
            ifid_inst_p1 <= bus.inst_in;
            ifid_pc4_p1  <= pc4_p0;
            ifid_vld_p1  <= 1'b1;
        end
    end

    // ---- stage p2: ID/EX control register ----
    // ID/EX control capture with bubble insertion.
    always_ff @(posedge clk) begin
        if (rst) begin
            idex_ctrl_p2 <= '0;
            idex_vld_p2  <= 1'b0;
        end else if (bus.EXNop) begin
            idex_ctrl_p2 <= '0;
            idex_vld_p2  <= 1'b0;
        end else begin
            idex_ctrl_p2 <= bus.id_ctrl_in;
            idex_vld_p2  <= ifid_vld_p1;
        end
    end

    // Debug event counters: clear has priority over counting.
    always_ff @(posedge clk) begin
        if (rst || bus.cnt_clr) begin
            stall_cnt_r  <= '0;
            flush_cnt_r  <= '0;
            bubble_cnt_r <= '0;
        end else begin
            stall_cnt_r  <= sat_inc(stall_cnt_r, stall_evt);
            flush_cnt_r  <= sat_inc(flush_cnt_r, flush_evt);
            bubble_cnt_r <= sat_inc(bubble_cnt_r, bubble_evt);
        end
    end

    assign bus.pc         = pc_p0;
    assign bus.pcsrc_err  = pcsrc_err_r;
    assign bus.ifid_inst  = ifid_inst_p1;
    assign bus.ifid_pc4   = ifid_pc4_p1;
    assign bus.ifid_valid = ifid_vld_p1;
    assign bus.idex_ctrl  = idex_ctrl_p2;
    assign bus.idex_valid = idex_vld_p2;
    assign bus.stall_cnt  = stall_cnt_r;
    assign bus.flush_cnt  = flush_cnt_r;
    assign bus.bubble_cnt = bubble_cnt_r;

endmodule
